// File: rtl/tlb_flush_sequencer.sv
// SFENCE.VMA engine: clears the whole TLB or walks it invalidating matching entries.
// Define TLB_FLUSH_ASID_EN to qualify selective flushes by ASID and global bit.
module tlb_flush_sequencer #(
    parameter  int TLB_ENTRIES = 16,
    parameter  int ASID_WIDTH  = 9,
    localparam int IW          = $clog2(TLB_ENTRIES)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  tlb_flush_i,
    input  logic                  tlb_flush_type_i,
    input  logic [31:0]           tlb_flush_vaddr_i,
    input  logic [31:0]           tlb_flush_asid_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  tlb_rd_o,
    output logic [IW-1:0]         tlb_rd_idx_o,
    input  logic                  tlb_tag_valid_i,
    input  logic                  tlb_tag_global_i,
    input  logic                  tlb_tag_mega_i,
    input  logic [19:0]           tlb_tag_vpn_i,
    input  logic [ASID_WIDTH-1:0] tlb_tag_asid_i,
    output logic                  tlb_inv_o,
    output logic [IW-1:0]         tlb_inv_idx_o,
    output logic                  tlb_inv_all_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALL,
        S_WALK,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [19:0]           r_vpn;
    logic [ASID_WIDTH-1:0] r_asid;
    logic                  r_pend;
    logic                  r_pend_type;
    logic [19:0]           r_pend_vpn;
    logic [ASID_WIDTH-1:0] r_pend_asid;
    logic                  r_cmp;
    logic [IW-1:0]         r_inv_idx;

    logic                  w_accept;
    logic                  w_take_req;
    logic                  w_take_pend;
    logic                  w_go;
    logic                  w_go_type;
    logic [19:0]           w_go_vpn;
    logic [ASID_WIDTH-1:0] w_go_asid;
    logic                  w_queue_req;
    logic                  w_last;
    logic                  w_vpn_hit;
    logic                  w_asid_hit;
    logic                  w_unused;

    always_comb begin
        w_accept    = (r_state == S_IDLE) || (r_state == S_DONE);
        w_take_req  = w_accept && tlb_flush_i;
        w_take_pend = (r_state == S_DONE) && r_pend && !tlb_flush_i;
        w_go        = w_take_req || w_take_pend;
        w_go_type   = w_take_req ? tlb_flush_type_i : r_pend_type;
        w_go_vpn    = w_take_req ? tlb_flush_vaddr_i[31:12] : r_pend_vpn;
        w_go_asid   = w_take_req ? tlb_flush_asid_i[ASID_WIDTH-1:0]
                                 : r_pend_asid;
        w_queue_req = tlb_flush_i && !w_accept;
        w_last      = (tlb_rd_idx_o == IW'(TLB_ENTRIES - 1));
    end

    // Megapage tags only carry a meaningful VPN[1] field.
    always_comb begin
        if (tlb_tag_mega_i)
            w_vpn_hit = (tlb_tag_vpn_i[19:10] == r_vpn[19:10]);
        else
            w_vpn_hit = (tlb_tag_vpn_i == r_vpn);
    end

`ifdef TLB_FLUSH_ASID_EN
    assign w_asid_hit = !tlb_tag_global_i && (tlb_tag_asid_i == r_asid);
    assign w_unused   = ^{tlb_flush_vaddr_i[11:0],
                          tlb_flush_asid_i[31:ASID_WIDTH]};
`else
    assign w_asid_hit = 1'b1;
    assign w_unused   = ^{tlb_flush_vaddr_i[11:0],
                          tlb_flush_asid_i[31:ASID_WIDTH],
                          tlb_tag_global_i, tlb_tag_asid_i, r_asid};
`endif

    // Tag data arrives one cycle after the read, so the compare is a stage behind.
    assign tlb_inv_o     = r_cmp && tlb_tag_valid_i && w_vpn_hit && w_asid_hit;
    assign tlb_inv_idx_o = r_inv_idx;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= S_IDLE;
            r_vpn         <= '0;
            r_asid        <= '0;
            r_pend        <= 1'b0;
            r_pend_type   <= 1'b0;
            r_pend_vpn    <= '0;
            r_pend_asid   <= '0;
            r_cmp         <= 1'b0;
            r_inv_idx     <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            tlb_rd_o      <= 1'b0;
            tlb_rd_idx_o  <= '0;
            tlb_inv_all_o <= 1'b0;
        end else begin
            r_cmp         <= tlb_rd_o;
            r_inv_idx     <= tlb_rd_idx_o;
            done_o        <= 1'b0;
            tlb_inv_all_o <= 1'b0;
            if (w_queue_req) begin
                r_pend      <= 1'b1;
                r_pend_type <= tlb_flush_type_i;
                r_pend_vpn  <= tlb_flush_vaddr_i[31:12];
                r_pend_asid <= tlb_flush_asid_i[ASID_WIDTH-1:0];
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_go) begin
                        r_vpn  <= w_go_vpn;
                        r_asid <= w_go_asid;
                        r_pend <= 1'b0;
                        busy_o <= 1'b1;
                        if (w_go_type) begin
                            r_state      <= S_WALK;
                            tlb_rd_o     <= 1'b1;
                            tlb_rd_idx_o <= '0;
                        end else begin
                            r_state       <= S_ALL;
                            tlb_inv_all_o <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        busy_o  <= 1'b0;
                    end
                end
                S_ALL: begin
                    r_state <= S_DONE;
                    done_o  <= 1'b1;
                end
                S_WALK: begin
                    if (w_last) begin
                        r_state  <= S_DRAIN;
                        tlb_rd_o <= 1'b0;
                    end else begin
                        tlb_rd_idx_o <= tlb_rd_idx_o + IW'(1);
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    done_o  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/tlb_flush_sequencer.md
# tlb_flush_sequencer

Multi-cycle engine that executes SFENCE.VMA TLB invalidations for the Aquila core. It sits directly downstream of the pipeline controller and consumes its one-cycle TLB-flush request, flush type, virtual address and ASID. It then either clears the whole TLB at once or walks every TLB entry and invalidates the matching ones. While it runs, it holds `busy_o` so the core stalls until the translation state is consistent.

## Interface
- `TLB_ENTRIES`, 16, number of TLB entries; power of two, ≥ 2; `IW = $clog2(TLB_ENTRIES)`.
- `ASID_WIDTH`, 9, number of ASID bits compared (Sv32).

- `clk_i`  in  1  core clock.
- `rst_ni`  in  1  reset; asynchronous, active-low (already decided).
- `tlb_flush_i`  in  1  one-cycle flush request.
- `tlb_flush_type_i`  in  1  0 = flush all entries; 1 = selective flush by vaddr/ASID.
- `tlb_flush_vaddr_i`  in  32  virtual address to flush (selective).
- `tlb_flush_asid_i`  in  32  ASID to flush; only `[ASID_WIDTH-1:0]` is used.
- `busy_o`  out  1  sequencer active; the core stalls on it.
- `done_o`  out  1  one-cycle pulse when a flush completes.
- `tlb_rd_o`  out  1  tag read strobe.
- `tlb_rd_idx_o`  out  IW  tag read index.
- `tlb_tag_valid_i`, `tlb_tag_global_i`, `tlb_tag_mega_i`  in  1 each  tag fields for the entry read in the previous cycle.
- `tlb_tag_vpn_i`  in  20  tag VPN for that entry.
- `tlb_tag_asid_i`  in  ASID_WIDTH  tag ASID for that entry.
- `tlb_inv_o`  out  1  invalidate the entry at `tlb_inv_idx_o`.
- `tlb_inv_idx_o`  out  IW  index of the entry to invalidate.
- `tlb_inv_all_o`  out  1  clear every valid bit.

## Operation
- States: IDLE, ALL, WALK, DRAIN, DONE.
- Reset: all outputs are 0 and the state is IDLE. Reset mid-operation aborts the walk, drops any pending request and completes no further invalidations.
- Acceptance: IDLE and DONE sample `tlb_flush_i`. On a request, the type, vaddr and ASID are latched.
  - Type 0 → ALL.
  - Type 1 → WALK with index = 0.
  - No request → IDLE.
- ALL: `tlb_inv_all_o` = 1 for one cycle, then → DONE.
- WALK: `tlb_rd_o` = 1 and `tlb_rd_idx_o` = index; the index increments each cycle. After issuing `TLB_ENTRIES-1` → DRAIN.
- Compare stage: in the cycle after each read (WALK cycles 2..N, and DRAIN), the returned tag is compared against the latched request.
  - Matching entries get `tlb_inv_o` = 1 with `tlb_inv_idx_o` = the previous read index; this is registered from the index, but `tlb_inv_o` itself is combinational from the tag.
  - DRAIN lasts one cycle, then → DONE.
- Match rule:
  - The entry must have `valid` = 1.
  - If `mega` = 1: `vpn[19:10] == vaddr[31:22]`.
  - If `mega` = 0: `vpn == vaddr[31:12]`.
  - The ASID term is set by the Configuration macro.
- DONE: `done_o` = 1 for exactly one cycle.
- Pending request: a `tlb_flush_i` seen in ALL, WALK or DRAIN is latched into a 1-deep pending slot.
  - DONE then starts the pending request instead of returning to IDLE.
  - A second overlapping request overwrites the slot (last wins).
  - A request arriving in DONE itself is accepted directly and takes priority over the pending slot, which is then cleared.
- `busy_o` = 1 in ALL, WALK, DRAIN and DONE.

## Timing
- Request sampled at edge 0.
- Type 0:
  - cycle 1: ALL, `tlb_inv_all_o` = 1.
  - cycle 2: DONE.
  - `busy_o` is high for 2 cycles.
- Type 1 with N = `TLB_ENTRIES`:
  - Reads in cycles 1..N, indices 0..N-1.
  - Invalidates in cycles 2..N+1; cycle N+1 is DRAIN.
  - `done_o` in cycle N+2.
  - `busy_o` is high for N+2 cycles.
- The TLB returns tag data one cycle after `tlb_rd_o`. Read and invalidate ports are independent, so both may be active in the same cycle on different indices.
- Index wrap: the counter is IW bits wide and never wraps inside a walk; it resets to 0 on each new walk.

## Configuration
- `TLB_FLUSH_ASID_EN` defined:
  - A selective flush also requires `tlb_tag_global_i` = 0 and `tlb_tag_asid_i == tlb_flush_asid_i[ASID_WIDTH-1:0]`.
  - Global entries survive a selective flush.
- Not defined: ASID and global bit are ignored, and a selective flush matches on VPN only.

## Test plan
- Reset low mid-WALK at index 5 → all outputs 0 next cycle. After release, a type-0 request gives `tlb_inv_all_o` in cycle 1 and `done_o` in cycle 2.
- Type 1, vaddr 0x0040_3000, entry 7 tag vpn 0x00403 valid, others non-matching, N = 16 → exactly one `tlb_inv_o` with idx 7 in cycle 9; `done_o` in cycle 18.
- Megapage entry 3 with vpn[19:10] = 0x001 and vaddr 0x0040_0000 → idx 3 invalidated; the same tag with `mega` = 0 and vpn 0x00401 → not invalidated.
- With `TLB_FLUSH_ASID_EN`: entry 2 asid 5 / entry 4 asid 6 / entry 6 global, all with the same vpn, request asid 5 → only idx 2 invalidated. Without the macro → idx 2, 4 and 6 invalidated.
- Type-0 request in WALK cycle 3, then a type-1 request in cycle 4 → the type-1 request is the one executed after the first `done_o`; `busy_o` stays high continuously between the two flushes.
- Request in the DONE cycle → the next flush starts the following cycle and `busy_o` never drops.
